// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone-style arbiter.
// ADDR_SIZE / WORD_SIZE default here unless a project defines.svh already set them.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [`WORD_SIZE-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: first requester after last_idx, wrapping modulo N.
// Purely combinational, zero latency.
module rr_picker #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_idx_i,
    output logic                 vld_o,
    output logic [IDX_W-1:0]     idx_o
);

    always_comb begin
        int cand;
        vld_o = 1'b0;
        idx_o = '0;
        cand  = 0;
        // Walk offsets farthest-first so the nearest requester after last_idx wins.
        for (int i = N_MASTERS; i >= 1; i--) begin
            cand = (int'(last_idx_i) + i) % N_MASTERS;
            if (req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave among N masters; one grant per transaction.
// Grant costs 1 cycle, acks pass through combinationally; a watchdog ends unacked transfers with Bus_err.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [N_MASTERS*`ADDR_SIZE-1:0] M_addr,
    input  logic [N_MASTERS-1:0]            M_cs,
    input  logic [N_MASTERS-1:0]            M_we,
    input  logic [N_MASTERS*`WORD_SIZE-1:0] M_wdata,
    output logic [`WORD_SIZE-1:0]           M_rdata,
    output logic [N_MASTERS-1:0]            M_ack,
    output logic [`ADDR_SIZE-1:0]           S_addr,
    output logic                            S_cs,
    output logic                            S_we,
    output logic [`WORD_SIZE-1:0]           S_wdata,
    input  logic [`WORD_SIZE-1:0]           S_rdata,
    input  logic                            S_ack,
    output logic [N_MASTERS-1:0]            Grant,
    output logic                            Bus_err
);

    localparam int          AW      = `ADDR_SIZE;
    localparam int          DW      = `WORD_SIZE;
    localparam int          IDX_W   = $clog2(N_MASTERS);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;

    rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i      (M_cs),
        .last_idx_i (last_idx_q),
        .vld_o      (pick_vld),
        .idx_o      (pick_idx)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(N_MASTERS - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        M_rdata     = '0;
        M_ack       = '0;
        S_addr      = '0;
        S_cs        = 1'b0;
        S_we        = 1'b0;
        S_wdata     = '0;
        Bus_err     = 1'b0;

        // Outputs are held at zero while reset is asserted so a dying transfer cannot ack.
        if (!Rst) begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_idx_d       = pick_idx;
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        cnt_d             = '0;
                        state_d           = BUSY;
                    end
                end
                BUSY: begin
                    S_addr  = M_addr[int'(grant_idx_q)*AW +: AW];
                    S_we    = M_we[grant_idx_q];
                    S_wdata = M_wdata[int'(grant_idx_q)*DW +: DW];
                    S_cs    = M_cs[grant_idx_q];
                    if (S_ack) begin
                        M_ack[grant_idx_q] = 1'b1;
                        M_rdata            = S_rdata;
                        state_d            = IDLE;
                        last_idx_d         = grant_idx_q;
                        grant_d            = '0;
                    end else if (!M_cs[grant_idx_q]) begin
                        state_d    = IDLE;
                        last_idx_d = grant_idx_q;
                        grant_d    = '0;
                    end else if (cnt_q == TO_LAST) begin
                        M_ack[grant_idx_q] = 1'b1;
                        M_rdata            = BUS_ERR_DATA;
                        Bus_err            = 1'b1;
                        S_cs               = 1'b0;
                        state_d            = IDLE;
                        last_idx_d         = grant_idx_q;
                        grant_d            = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign Grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters and a short watchdog.
// Inputs change 1 ns after the rising edge; outputs are checked 1-2 ns after it.
module tb_wb_arbiter;

    localparam int AW = `ADDR_SIZE;
    localparam int DW = `WORD_SIZE;

    logic                Clk = 1'b0;
    logic                Rst;
    logic [2*AW-1:0]     M_addr;
    logic [1:0]          M_cs;
    logic [1:0]          M_we;
    logic [2*DW-1:0]     M_wdata;
    logic [DW-1:0]       M_rdata;
    logic [1:0]          M_ack;
    logic [AW-1:0]       S_addr;
    logic                S_cs;
    logic                S_we;
    logic [DW-1:0]       S_wdata;
    logic [DW-1:0]       S_rdata;
    logic                S_ack;
    logic [1:0]          Grant;
    logic                Bus_err;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(
        .N_MASTERS      (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .M_addr  (M_addr),
        .M_cs    (M_cs),
        .M_we    (M_we),
        .M_wdata (M_wdata),
        .M_rdata (M_rdata),
        .M_ack   (M_ack),
        .S_addr  (S_addr),
        .S_cs    (S_cs),
        .S_we    (S_we),
        .S_wdata (S_wdata),
        .S_rdata (S_rdata),
        .S_ack   (S_ack),
        .Grant   (Grant),
        .Bus_err (Bus_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;

        Rst     = 1'b1;
        M_addr  = '0;
        M_cs    = '0;
        M_we    = '0;
        M_wdata = '0;
        S_rdata = '0;
        S_ack   = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_grant",   32'(Grant),   32'h0);
        chk("rst_scs",     32'(S_cs),    32'h0);
        chk("rst_mack",    32'(M_ack),   32'h0);
        chk("rst_buserr",  32'(Bus_err), 32'h0);
        chk("rst_mrdata",  M_rdata,      32'h0);
        Rst = 1'b0;
        tick();

        // Single read from master 0, slave acks on the third BUSY cycle
        M_cs = 2'b01;
        M_addr[31:0] = 32'h7F;
        settle();
        chk("t1_arb_scs",   32'(S_cs),  32'h0);
        chk("t1_arb_grant", 32'(Grant), 32'h0);
        tick();
        chk("t1_scs",   32'(S_cs),  32'h1);
        chk("t1_saddr", S_addr,     32'h7F);
        chk("t1_grant", 32'(Grant), 32'h1);
        tick();
        chk("t1_wait_scs",  32'(S_cs),  32'h1);
        chk("t1_wait_mack", 32'(M_ack), 32'h0);
        tick();
        S_ack   = 1'b1;
        S_rdata = 32'hFFFF_F000;
        settle();
        chk("t1_mack",   32'(M_ack), 32'h1);
        chk("t1_mrdata", M_rdata,    32'hFFFF_F000);
        tick();
        S_ack   = 1'b0;
        S_rdata = '0;
        M_cs    = 2'b00;
        settle();
        chk("t1_post_mack",  32'(M_ack), 32'h0);
        chk("t1_post_grant", 32'(Grant), 32'h0);
        chk("t1_post_rdata", M_rdata,    32'h0);

        // Simultaneous requests straight after reset: master 0 first, then master 1 write
        Rst = 1'b1;
        tick();
        Rst     = 1'b0;
        M_cs    = 2'b11;
        M_we    = 2'b10;
        M_addr  = {32'h10, 32'h20};
        M_wdata = {32'h0000_0FFF, 32'h0};
        tick();
        chk("t2_g0",     32'(Grant), 32'h1);
        chk("t2_swe0",   32'(S_we),  32'h0);
        chk("t2_saddr0", S_addr,     32'h20);
        S_ack   = 1'b1;
        S_rdata = 32'h55;
        settle();
        chk("t2_mack0", 32'(M_ack), 32'h1);
        tick();
        S_ack = 1'b0;
        M_cs  = 2'b10;
        settle();
        chk("t2_gap_scs",   32'(S_cs),  32'h0);
        chk("t2_gap_grant", 32'(Grant), 32'h0);
        chk("t2_gap_mack",  32'(M_ack), 32'h0);
        tick();
        chk("t2_g1",     32'(Grant), 32'h2);
        chk("t2_swe1",   32'(S_we),  32'h1);
        chk("t2_swdata", S_wdata,    32'h0000_0FFF);
        chk("t2_saddr1", S_addr,     32'h10);
        S_ack = 1'b1;
        settle();
        chk("t2_mack1", 32'(M_ack), 32'h2);
        tick();
        S_ack = 1'b0;
        M_cs  = 2'b00;
        M_we  = 2'b00;
        settle();
        chk("t2_post_mack", 32'(M_ack), 32'h0);

        // Fairness: both request continuously, then only master 1
        M_cs = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("t3_rr_grant", 32'(Grant), 32'(exp_g));
            S_ack = 1'b1;
            settle();
            chk("t3_rr_mack", 32'(M_ack), 32'(exp_g));
            tick();
            S_ack = 1'b0;
            settle();
            chk("t3_rr_idle", 32'(Grant), 32'h0);
        end
        M_cs = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_solo_grant", 32'(Grant), 32'h2);
            S_ack = 1'b1;
            settle();
            chk("t3_solo_mack", 32'(M_ack), 32'h2);
            tick();
            S_ack = 1'b0;
        end
        M_cs = 2'b00;

        // Watchdog: slave never acks master 0
        M_cs = 2'b01;
        M_addr[31:0] = 32'h44;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_wait_scs",  32'(S_cs),    32'h1);
            chk("t4_wait_mack", 32'(M_ack),   32'h0);
            chk("t4_wait_err",  32'(Bus_err), 32'h0);
            tick();
        end
        chk("t4_to_mack",  32'(M_ack),   32'h1);
        chk("t4_to_rdata", M_rdata,      32'hDEAD_BEEF);
        chk("t4_to_err",   32'(Bus_err), 32'h1);
        chk("t4_to_scs",   32'(S_cs),    32'h0);
        tick();
        M_cs = 2'b00;
        settle();
        chk("t4_post_err",   32'(Bus_err), 32'h0);
        chk("t4_post_grant", 32'(Grant),   32'h0);
        M_cs = 2'b10;
        tick();
        chk("t4_next_grant", 32'(Grant), 32'h2);
        chk("t4_next_scs",   32'(S_cs),  32'h1);
        S_ack = 1'b1;
        settle();
        chk("t4_next_mack", 32'(M_ack),   32'h2);
        chk("t4_next_err",  32'(Bus_err), 32'h0);
        tick();
        S_ack = 1'b0;
        M_cs  = 2'b00;

        // Master abort mid-BUSY, then a stray slave ack while idle
        M_cs = 2'b01;
        tick();
        chk("t5_scs", 32'(S_cs), 32'h1);
        M_cs = 2'b00;
        settle();
        chk("t5_abort_scs",  32'(S_cs),  32'h0);
        chk("t5_abort_mack", 32'(M_ack), 32'h0);
        tick();
        chk("t5_abort_grant", 32'(Grant), 32'h0);
        S_ack   = 1'b1;
        S_rdata = 32'h1234;
        settle();
        chk("t5_stray_mack",  32'(M_ack), 32'h0);
        chk("t5_stray_rdata", M_rdata,    32'h0);
        tick();
        S_ack   = 1'b0;
        S_rdata = '0;
        settle();
        chk("t5_stray_grant", 32'(Grant), 32'h0);
        chk("t5_stray_scs",   32'(S_cs),  32'h0);

        // Reset during BUSY drops the transfer; master 0 wins afterwards
        M_cs = 2'b11;
        tick();
        chk("t6_busy_grant", 32'(Grant), 32'h2);
        Rst     = 1'b1;
        S_ack   = 1'b1;
        S_rdata = 32'hABC;
        settle();
        chk("t6_rst_mack", 32'(M_ack), 32'h0);
        tick();
        Rst   = 1'b0;
        S_ack = 1'b0;
        settle();
        chk("t6_post_grant", 32'(Grant),   32'h0);
        chk("t6_post_scs",   32'(S_cs),    32'h0);
        chk("t6_post_mack",  32'(M_ack),   32'h0);
        chk("t6_post_err",   32'(Bus_err), 32'h0);
        tick();
        chk("t6_first_grant", 32'(Grant), 32'h1);
        S_ack = 1'b1;
        settle();
        chk("t6_first_mack", 32'(M_ack), 32'h1);
        tick();
        S_ack = 1'b0;
        M_cs  = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
